// File: rtl/rtc_pkg.sv
// Shared types and helpers for the RTC bus engine: FSM state encoding,
// timed-phase count and index-width helper.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_STRB, A_HOLD, D_SETUP, D_STRB, D_HOLD, END
  } bus_state_t;

  // Timed phases are encoded 1..N_PHASES, so they step through in order.
  localparam int N_PHASES = 6;

  function automatic int shadow_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bus_state_t next_phase(input bus_state_t s);
    return (int'(s) >= N_PHASES) ? END : bus_state_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/rtc_shadow_regs.sv
// Flop-based shadow copy of RTC registers: one synchronous write port,
// one combinational read port, cleared by reset.
module rtc_shadow_regs
  import rtc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int N_SHADOW = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              we,
  input  logic [shadow_idx_w(N_SHADOW)-1:0] waddr,
  input  logic [DATA_W-1:0]                 wdata,
  input  logic [shadow_idx_w(N_SHADOW)-1:0] raddr,
  output logic [DATA_W-1:0]                 rdata
);

  logic [DATA_W-1:0] regs_q [N_SHADOW];

  // NOTE: this file is built from flops, so clearing every entry on reset is
  // legal; a RAM macro could not be cleared like this.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SHADOW; i++) regs_q[i] <= '0;
    end else if (we && int'(waddr) < N_SHADOW) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < N_SHADOW) ? regs_q[raddr] : '0;

endmodule

// File: rtl/rtc_bus_engine.sv
// Multiplexed address/data bus master for the RTC chip with host request
// port and an irq-triggered sweep of RTC registers into a shadow file.
module rtc_bus_engine
  import rtc_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter int                T_PHASE       = 4,
  parameter int                N_SHADOW      = 16,
  parameter logic [DATA_W-1:0] REFRESH_FIRST = 8'h21,
  parameter int                REFRESH_COUNT = 9
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  input  logic                              req_write,
  input  logic [DATA_W-1:0]                 req_addr,
  input  logic [DATA_W-1:0]                 req_data,
  output logic                              req_ready,
  output logic                              rsp_valid,
  output logic [DATA_W-1:0]                 rsp_data,
  input  logic                              irq,
  output logic                              sweep_busy,
  output logic                              sweep_done,
  input  logic [shadow_idx_w(N_SHADOW)-1:0] shadow_addr,
  output logic [DATA_W-1:0]                 shadow_data,
  input  logic [DATA_W-1:0]                 bus_in,
  output logic [DATA_W-1:0]                 bus_out,
  output logic                              bus_oe,
  output logic                              CS,
  output logic                              AD,
  output logic                              RD,
  output logic                              WR
);

  localparam int SA_W = shadow_idx_w(N_SHADOW);
  localparam int PH_W = shadow_idx_w(T_PHASE);
  localparam logic [SA_W-1:0]   IDX_LAST = SA_W'(REFRESH_COUNT - 1);
  localparam logic [DATA_W:0]   WIN_LO   = {1'b0, REFRESH_FIRST};
  localparam logic [DATA_W:0]   WIN_HI   = WIN_LO + (DATA_W + 1)'(REFRESH_COUNT);

  bus_state_t        state, state_d;
  logic [PH_W-1:0]   ph;
  logic              is_write, is_sweep;
  logic [DATA_W-1:0] addr_q, data_q, cap_q;
  logic              irq_q, pending, active, sweep_done_q;
  logic [SA_W-1:0]   idx;

  logic              accept, launch_sweep, end_sweep, last_sweep, irq_edge, in_window;
  logic              sh_we;
  logic [SA_W-1:0]   sh_waddr;
  logic [DATA_W-1:0] sh_wdata;

  // NOTE: every variable gets a default before the case, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    accept       = 1'b0;
    launch_sweep = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = A_SETUP;
        end else if (pending || active) begin
          launch_sweep = 1'b1;
          state_d      = A_SETUP;
        end
      end
      END:     state_d = IDLE;
      default: if (ph == '0) state_d = next_phase(state);
    endcase
  end

  always_comb begin
    CS      = 1'b1;
    AD      = 1'b1;
    RD      = 1'b1;
    WR      = 1'b1;
    bus_oe  = 1'b0;
    bus_out = '0;
    case (state)
      A_SETUP, A_STRB, A_HOLD: begin
        CS      = 1'b0;
        AD      = 1'b0;
        bus_oe  = 1'b1;
        bus_out = addr_q;
        WR      = (state != A_STRB);
      end
      D_SETUP, D_STRB, D_HOLD: begin
        CS = 1'b0;
        if (is_write) begin
          bus_oe  = 1'b1;
          bus_out = data_q;
          WR      = (state != D_STRB);
        end else begin
          RD = (state != D_STRB);
        end
      end
      default: ;
    endcase
  end

  assign irq_edge   = irq && !irq_q;
  assign end_sweep  = (state == END) && is_sweep;
  assign last_sweep = end_sweep && (idx == IDX_LAST);
  assign in_window  = ({1'b0, addr_q} >= WIN_LO) && ({1'b0, addr_q} < WIN_HI);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ph           <= '0;
      is_write     <= 1'b0;
      is_sweep     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cap_q        <= '0;
      rsp_data     <= '0;
      irq_q        <= 1'b0;
      pending      <= 1'b0;
      active       <= 1'b0;
      idx          <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state <= state_d;
      irq_q <= irq;

      if (state_d != state) ph <= PH_W'(T_PHASE - 1);
      else if (ph != '0)    ph <= ph - PH_W'(1);

      if (accept) begin
        is_write <= req_write;
        is_sweep <= 1'b0;
        addr_q   <= req_addr;
        data_q   <= req_data;
      end else if (launch_sweep) begin
        is_write <= 1'b0;
        is_sweep <= 1'b1;
        addr_q   <= REFRESH_FIRST + DATA_W'(idx);
      end

      if (state == D_STRB && ph == '0 && !is_write) cap_q <= bus_in;
      if (state == D_HOLD && ph == '0 && !is_write && !is_sweep) rsp_data <= cap_q;

      // A fresh edge always wins, so an edge coinciding with the pending->active
      // conversion or with the final sweep END still queues another sweep.
      pending <= (pending && !(launch_sweep && !active)) || irq_edge;

      if (launch_sweep)    active <= 1'b1;
      else if (last_sweep) active <= 1'b0;

      if (last_sweep)     idx <= '0;
      else if (end_sweep) idx <= idx + SA_W'(1);

      sweep_done_q <= last_sweep;
    end
  end

  assign req_ready  = (state == IDLE) && !reset;
  assign rsp_valid  = (state == END) && !is_sweep && !reset;
  assign sweep_busy = pending || active;
  assign sweep_done = sweep_done_q;

  // Host writes inside the sweep window keep the shadow coherent.
  assign sh_we    = (state == END) && (is_sweep || (is_write && in_window));
  assign sh_waddr = is_sweep ? idx : SA_W'(addr_q - REFRESH_FIRST);
  assign sh_wdata = is_sweep ? cap_q : data_q;

  rtc_shadow_regs #(
    .DATA_W   (DATA_W),
    .N_SHADOW (N_SHADOW)
  ) u_shadow (
    .clk   (clk),
    .reset (reset),
    .we    (sh_we),
    .waddr (sh_waddr),
    .wdata (sh_wdata),
    .raddr (shadow_addr),
    .rdata (shadow_data)
  );

endmodule
